muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative multiply/divide controller for the EX stage. It implements MULT, MULTU, DIV and DIVU by sequencing the shared 32-bit ALU for one ADD per multiply step, or one SLTU plus one SUB per divide step. Sign handling and the final HI/LO results are kept in the block's own registers. While the block owns the ALU, it drives the ALU operands and opcode through the EX-stage operand mux.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- op_a  in  32  multiplicand / dividend; sampled with start.
- op_b  in  32  multiplier / divisor; sampled with start.
- flush  in  1  abort in-flight operation (pipeline exception).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when hi/lo update.
- hi  out  32  product[63:32] / remainder.
- lo  out  32  product[31:0] / quotient.
- alu_own  out  1  high in MUL_ITER, DIV_CMP, DIV_SUB; EX mux selects alu_a/alu_b/alu_op.
- alu_a, alu_b  out  32  ALU operands.
- alu_op  out  4  ALU opcode: ADD 4'b0010, SUB 4'b0110, SLTU 4'b0100.
- alu_result  in  32  combinational ALU result, same cycle.

## Operation
- States: IDLE, PREP, MUL_ITER, DIV_CMP, DIV_SUB, FIXUP, DONE. 5-bit iteration counter.
- IDLE: start=1 → latch op, op_a, op_b → PREP.
- PREP:
  - Signed ops: sa=op_a[31], sb=op_b[31]; operands replaced by two's-complement magnitude. Magnitude of 0x80000000 is 0x80000000.
  - Unsigned ops: sa=sb=0.
  - Counter cleared. Next state MUL_ITER or DIV_CMP.
- MUL_ITER, 32 cycles:
  - Drive alu_a=acc_hi, alu_b=mcand, op ADD.
  - If acc_lo[0]: s=alu_result, c=(s<acc_hi unsigned, computed internally). Else s=acc_hi, c=0.
  - {acc_hi,acc_lo} <= {c,s,acc_lo[31:1]}.
  - acc_lo is initialised to |a|, acc_hi to 0.
  - Leave to FIXUP after counter=31.
- DIV_CMP:
  - Drive alu_a={rem[30:0],quo[31]}, alu_b=divisor, op SLTU.
  - Latch rem<=alu_a, top<=rem[31], lt<=alu_result[0], quo<=quo<<1.
  - Next state DIV_SUB.
- DIV_SUB:
  - Drive alu_a=rem, alu_b=divisor, op SUB.
  - If top|~lt: rem<=alu_result, quo[0]<=1.
  - Back to DIV_CMP; after 32 iterations go to FIXUP.
  - rem is initialised to 0, quo to |a|.
- FIXUP:
  - MULT: negate the 64-bit product if sa^sb.
  - DIV: negate quotient if sa^sb; negate remainder if sa.
  - Write hi/lo. Next state DONE.
- DONE: done=1 for one cycle → IDLE.
- Divide by zero: normal latency; hi=original op_a, lo=32'hFFFF_FFFF (override in FIXUP).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Outside owned states: alu_a=alu_b=0, alu_op=ADD, alu_own=0.

## Timing
- rst: state IDLE; busy, done, alu_own=0; hi=lo=0; alu_a=alu_b=0; alu_op=ADD.
- Start sampled at edge 0:
  - Multiply: done high in cycle 35 (PREP 1 + 32 iterations + FIXUP 1 + DONE).
  - Divide: done high in cycle 67 (64 iteration cycles, fixed, data-independent).
- hi/lo update at the edge entering DONE and hold until the next DONE or rst.
- start while busy: ignored, no queueing. start in the DONE cycle: ignored. Accepted from IDLE on the following cycle.
- flush: takes effect at the next edge from any non-IDLE state, including DONE. Returns to IDLE; hi/lo unchanged; no done pulse. flush and start together in IDLE: start ignored.
- rst mid-operation: same as flush, plus hi/lo cleared. rst has priority over flush and start.
- alu_own asserts the cycle after PREP and drops the cycle after the last iteration.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 35 cycles after start.
- MULT 0xFFFFFFFD(−3)×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0×x → 0/0.
- DIVU 100/7 → lo=14, hi=2 at cycle 67; DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/−2 → lo=0xFFFFFFFD, hi=1. DIV by 0 of 5 → hi=5, lo=0xFFFFFFFF.
- Start MULTU; pulse start with new operands at cycle 10 → ignored. Flush at cycle 20 → busy=0 at cycle 21, no done, hi/lo keep the previous result.
- rst at cycle 40 of a DIVU → all outputs at reset values next cycle. Throughout every test, alu_own=0 and alu_op=ADD whenever the state is not an iteration state.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the EX stage. It borrows the shared ALU for one ADD
// per multiply step, or for one SLTU plus one SUB per divide step. Sign fixup and the HI/LO
// result registers live here.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        alu_own,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result
);

   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluSub  = 4'b0110;
   localparam logic [3:0] AluSltu = 4'b0100;

   typedef enum logic [2:0] {
      StIdle, StPrep, StMulIter, StDivCmp, StDivSub, StFixup, StDone
   } state_e;

   state_e      state_q;
   logic [1:0]  op_q;
   logic [31:0] a_q;       // original op_a, kept for the divide-by-zero result
   logic [31:0] b_q;       // op_b, replaced by |op_b| in PREP (multiplicand / divisor)
   logic        sa_q, sb_q;
   logic [31:0] acc_hi_q;  // product high half / partial remainder
   logic [31:0] acc_lo_q;  // product low half / quotient
   logic        top_q, lt_q;
   logic [4:0]  cnt_q;
   logic [31:0] hi_q, lo_q;

   logic [31:0] mul_s;
   logic        mul_c;
   logic [31:0] div_shift;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
   logic        signed_op;

   // Per-step datapath values and final sign corrections.
   always_comb begin
      signed_op = ~op_q[0];
      mul_s     = acc_lo_q[0] ? alu_result : acc_hi_q;
      // Carry out of the 32-bit add recovered from the wrapped sum.
      mul_c     = acc_lo_q[0] & (alu_result < acc_hi_q);
      div_shift = {acc_hi_q[30:0], acc_lo_q[31]};
      prod_fix  = {acc_hi_q, acc_lo_q};
      if (sa_q ^ sb_q) prod_fix = -prod_fix;
      quo_fix   = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
      rem_fix   = sa_q ? -acc_hi_q : acc_hi_q;
   end

   // Sequencer state, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         top_q    <= 1'b0;
         lt_q     <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (flush && state_q != StIdle) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !flush) begin
                  op_q    <= op;
                  a_q     <= op_a;
                  b_q     <= op_b;
                  state_q <= StPrep;
               end
            end
            StPrep: begin
               sa_q     <= signed_op & a_q[31];
               sb_q     <= signed_op & b_q[31];
               acc_lo_q <= (signed_op & a_q[31]) ? -a_q : a_q;
               b_q      <= (signed_op & b_q[31]) ? -b_q : b_q;
               acc_hi_q <= '0;
               cnt_q    <= '0;
               state_q  <= op_q[1] ? StDivCmp : StMulIter;
            end
            StMulIter: begin
               acc_hi_q <= {mul_c, mul_s[31:1]};
               acc_lo_q <= {mul_s[0], acc_lo_q[31:1]};
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= StFixup;
            end
            StDivCmp: begin
               acc_hi_q <= div_shift;
               top_q    <= acc_hi_q[31];
               lt_q     <= alu_result[0];
               acc_lo_q <= {acc_lo_q[30:0], 1'b0};
               state_q  <= StDivSub;
            end
            StDivSub: begin
               // top covers a 33-bit partial remainder that always exceeds the divisor.
               if (top_q || !lt_q) begin
                  acc_hi_q    <= alu_result;
                  acc_lo_q[0] <= 1'b1;
               end
               cnt_q   <= cnt_q + 5'd1;
               state_q <= (cnt_q == 5'd31) ? StFixup : StDivCmp;
            end
            StFixup: begin
               if (!op_q[1]) begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end else if (b_q == 32'd0) begin
                  hi_q <= a_q;
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Status and ALU request decoded from the registered state.
   always_comb begin
      busy    = (state_q != StIdle);
      done    = (state_q == StDone);
      alu_own = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = AluAdd;
      unique case (state_q)
         StMulIter: begin
            alu_own = 1'b1;
            alu_a   = acc_hi_q;
            alu_b   = b_q;
            alu_op  = AluAdd;
         end
         StDivCmp: begin
            alu_own = 1'b1;
            alu_a   = div_shift;
            alu_b   = b_q;
            alu_op  = AluSltu;
         end
         StDivSub: begin
            alu_own = 1'b1;
            alu_a   = acc_hi_q;
            alu_b   = b_q;
            alu_op  = AluSub;
         end
         default: ;
      endcase
      hi = hi_q;
      lo = lo_q;
   end

endmodule
